crtc_timing: RTL

Programmable two-axis CRTC timing generator, the runtime-configurable successor to the fixed-parameter single-axis sync generator. One block drives both the horizontal and vertical axes from the pixel clock, with no derived clocks. It produces pixel/line positions, phase, active-video, sync and strobe outputs for the pixel fetch and DAC stages. Timing is loaded through a small register port into shadow registers, which take effect at the next frame boundary.

---
 rtl/crtc_pkg.sv | 19 +
 rtl/crtc_timing_if.sv | 11 +
 rtl/crtc_axis.sv | 63 ++++++
 rtl/crtc_timing.sv | 132 +++++++++++++
 4 files changed

// File: rtl/crtc_pkg.sv
// Shared constants for the CRTC timing generator: phase encoding and the
// shadow-register address map.
package crtc_pkg;

   localparam logic [1:0] PH_BACK   = 2'b00;
   localparam logic [1:0] PH_ACTIVE = 2'b01;
   localparam logic [1:0] PH_FRONT  = 2'b10;
   localparam logic [1:0] PH_SYNC   = 2'b11;

   localparam logic [2:0] CFG_H_BACK   = 3'd0;
   localparam logic [2:0] CFG_H_ACTIVE = 3'd1;
   localparam logic [2:0] CFG_H_FRONT  = 3'd2;
   localparam logic [2:0] CFG_H_SYNC   = 3'd3;
   localparam logic [2:0] CFG_V_BACK   = 3'd4;
   localparam logic [2:0] CFG_V_ACTIVE = 3'd5;
   localparam logic [2:0] CFG_V_FRONT  = 3'd6;
   localparam logic [2:0] CFG_V_SYNC   = 3'd7;

endpackage

// File: rtl/crtc_timing_if.sv
// Configuration write port of the CRTC: one shadow field per cfg_we strobe.
interface crtc_timing_if #(
   parameter int WIDTH = 12
);
   logic             cfg_we;
   logic [2:0]       cfg_addr;
   logic [WIDTH-1:0] cfg_wdata;

   modport master (output cfg_we, output cfg_addr, output cfg_wdata);
   modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata);
endinterface

// File: rtl/crtc_axis.sv
// One timing axis: position counter plus a phase down-counter that reloads
// from the next phase's length. Exposes next-state so the top can register
// decoded flags in step with the counters.
module crtc_axis
   import crtc_pkg::*;
#(
   parameter int               WIDTH    = 12,
   parameter logic [WIDTH-1:0] REM_INIT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic [WIDTH-1:0] len_back,
   input  logic [WIDTH-1:0] len_active,
   input  logic [WIDTH-1:0] len_front,
   input  logic [WIDTH-1:0] len_sync,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] count_nxt,
   output logic [1:0]       phase,
   output logic [1:0]       phase_nxt,
   output logic             last
);

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] rem_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         phase <= PH_BACK;
         rem   <= REM_INIT;
      end else begin
         count <= count_nxt;
         phase <= phase_nxt;
         rem   <= rem_nxt;
      end
   end

   // rem==0 marks the final count of the current phase
   always_comb begin
      count_nxt = count;
      phase_nxt = phase;
      rem_nxt   = rem;
      if (step) begin
         if (rem == '0) begin
            phase_nxt = phase + 2'd1;
            case (phase_nxt)
               PH_BACK:   rem_nxt = len_back;
               PH_ACTIVE: rem_nxt = len_active;
               PH_FRONT:  rem_nxt = len_front;
               default:   rem_nxt = len_sync;
            endcase
            count_nxt = (phase == PH_SYNC) ? '0 : count + WIDTH'(1);
         end else begin
            rem_nxt   = rem - WIDTH'(1);
            count_nxt = count + WIDTH'(1);
         end
      end
   end

   assign last = (phase == PH_SYNC) && (rem == '0);

endmodule

// File: rtl/crtc_timing.sv
// Two-axis programmable CRTC timing generator: shadow/live timing registers
// committed at frame end, two crtc_axis counters, registered video flags.
module crtc_timing
   import crtc_pkg::*;
#(
   parameter int               WIDTH         = 12,
   parameter logic [WIDTH-1:0] H_BACK_INIT   = WIDTH'(47),
   parameter logic [WIDTH-1:0] H_ACTIVE_INIT = WIDTH'(639),
   parameter logic [WIDTH-1:0] H_FRONT_INIT  = WIDTH'(15),
   parameter logic [WIDTH-1:0] H_SYNC_INIT   = WIDTH'(95),
   parameter logic [WIDTH-1:0] V_BACK_INIT   = WIDTH'(32),
   parameter logic [WIDTH-1:0] V_ACTIVE_INIT = WIDTH'(479),
   parameter logic [WIDTH-1:0] V_FRONT_INIT  = WIDTH'(9),
   parameter logic [WIDTH-1:0] V_SYNC_INIT   = WIDTH'(1),
   parameter bit               HSYNC_POL     = 1'b0,
   parameter bit               VSYNC_POL     = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   crtc_timing_if.slave     cfg,
   output logic [WIDTH-1:0] hcount,
   output logic [WIDTH-1:0] vcount,
   output logic [1:0]       hphase,
   output logic [1:0]       vphase,
   output logic             active,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start
);

   function automatic logic [WIDTH-1:0] init_len(input logic [2:0] a);
      case (a)
         CFG_H_BACK:   init_len = H_BACK_INIT;
         CFG_H_ACTIVE: init_len = H_ACTIVE_INIT;
         CFG_H_FRONT:  init_len = H_FRONT_INIT;
         CFG_H_SYNC:   init_len = H_SYNC_INIT;
         CFG_V_BACK:   init_len = V_BACK_INIT;
         CFG_V_ACTIVE: init_len = V_ACTIVE_INIT;
         CFG_V_FRONT:  init_len = V_FRONT_INIT;
         default:      init_len = V_SYNC_INIT;
      endcase
   endfunction

   logic [WIDTH-1:0] shadow  [8];
   logic [WIDTH-1:0] live    [8];
   logic [WIDTH-1:0] len_cur [8];

   logic [WIDTH-1:0] hcount_nxt, vcount_nxt;
   logic [1:0]       hphase_nxt, vphase_nxt;
   logic             h_last, v_last;
   logic             frame_end;

   assign frame_end = en && h_last && v_last;

   // Shadow writes land at any time; live copies the pre-write shadow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= init_len(3'(i));
            live[i]   <= init_len(3'(i));
         end
      end else begin
         if (cfg.cfg_we)
            shadow[cfg.cfg_addr] <= cfg.cfg_wdata;
         if (frame_end)
            for (int i = 0; i < 8; i++)
               live[i] <= shadow[i];
      end
   end

   // The frame-end reload must already see the lengths being committed.
   always_comb begin
      for (int i = 0; i < 8; i++)
         len_cur[i] = frame_end ? shadow[i] : live[i];
   end

   crtc_axis #(
      .WIDTH    (WIDTH),
      .REM_INIT (H_BACK_INIT)
   ) u_h_axis (
      .clk        (clk),
      .reset      (reset),
      .step       (en),
      .len_back   (len_cur[CFG_H_BACK]),
      .len_active (len_cur[CFG_H_ACTIVE]),
      .len_front  (len_cur[CFG_H_FRONT]),
      .len_sync   (len_cur[CFG_H_SYNC]),
      .count      (hcount),
      .count_nxt  (hcount_nxt),
      .phase      (hphase),
      .phase_nxt  (hphase_nxt),
      .last       (h_last)
   );

   crtc_axis #(
      .WIDTH    (WIDTH),
      .REM_INIT (V_BACK_INIT)
   ) u_v_axis (
      .clk        (clk),
      .reset      (reset),
      .step       (en && h_last),
      .len_back   (len_cur[CFG_V_BACK]),
      .len_active (len_cur[CFG_V_ACTIVE]),
      .len_front  (len_cur[CFG_V_FRONT]),
      .len_sync   (len_cur[CFG_V_SYNC]),
      .count      (vcount),
      .count_nxt  (vcount_nxt),
      .phase      (vphase),
      .phase_nxt  (vphase_nxt),
      .last       (v_last)
   );

   // Flags decoded from next-state so they line up with the counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active      <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         active      <= (hphase_nxt == PH_ACTIVE) && (vphase_nxt == PH_ACTIVE);
         hsync       <= (hphase_nxt == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= (vphase_nxt == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
         line_start  <= (hcount_nxt == '0);
         frame_start <= (hcount_nxt == '0) && (vcount_nxt == '0);
      end
   end

endmodule
